jstk2_spi_responder: RTL and testbench

//  SPI slave emulating a Pmod JSTK2 joystick, the device end of the link driven by pmod_jstk2.

---
 rtl/jstk2_spi_responder.sv | 168 ++++++++++++++++
 tb/tb_jstk2_spi_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/jstk2_spi_responder.sv
// jstk2_spi_responder: SPI mode-0 slave that stands in for a Pmod JSTK2 joystick.
// Snapshots X/Y/buttons at frame start and shifts them out on miso, captures
// the MOSI bytes, and decodes the SetLED command at frame end.
module jstk2_spi_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  CMD_SETLED  = 8'h84,
  parameter logic        IDLE_MISO   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [7:0]  fs_in,
  output logic        busy,
  output logic        txn_done,
  output logic        frame_error,
  output logic [7:0]  cmd_byte,
  output logic [23:0] led_rgb,
  output logic        led_valid
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  localparam logic [5:0] FRAME_BITS = 6'd40;
  localparam logic [5:0] CNT_SAT    = 6'd41;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync, fill;
  logic                   sck_d, cs_d, armed;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;

  state_t      state, state_nx;
  logic [39:0] tx_sh, tx_nx, rx_sh, rx_nx;
  logic [5:0]  bit_cnt, cnt_nx;
  logic        pend, pend_nx;
  logic        miso_nx, busy_nx, done_nx, err_nx, ledv_nx;
  logic [7:0]  cmd_nx;
  logic [23:0] led_nx;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  // A chip-select fall only counts once cs_n has been seen truly high after
  // reset, so a frame already running at reset release is ignored.
  assign cs_fall  = armed & cs_d & ~cs_s;
  assign cs_rise  = cs_s & ~cs_d;

  // Synchronise the SPI pins, register them once more for edge detection,
  // and arm frame detection once the pipeline holds real (post-reset) data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      fill      <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
      if (&fill && cs_s) armed <= 1'b1;
    end
  end

  // Frame state and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      tx_sh       <= '0;
      rx_sh       <= '0;
      bit_cnt     <= '0;
      pend        <= 1'b0;
      miso        <= IDLE_MISO;
      busy        <= 1'b0;
      txn_done    <= 1'b0;
      frame_error <= 1'b0;
      cmd_byte    <= '0;
      led_rgb     <= '0;
      led_valid   <= 1'b0;
    end else begin
      state       <= state_nx;
      tx_sh       <= tx_nx;
      rx_sh       <= rx_nx;
      bit_cnt     <= cnt_nx;
      pend        <= pend_nx;
      miso        <= miso_nx;
      busy        <= busy_nx;
      txn_done    <= done_nx;
      frame_error <= err_nx;
      cmd_byte    <= cmd_nx;
      led_rgb     <= led_nx;
      led_valid   <= ledv_nx;
    end
  end

  // Next-state logic: snapshot on cs_n fall, shift on sck edges, decode on cs_n rise.
  always_comb begin
    state_nx = state;
    tx_nx    = tx_sh;
    rx_nx    = rx_sh;
    cnt_nx   = bit_cnt;
    pend_nx  = pend;
    miso_nx  = miso;
    busy_nx  = busy;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    cmd_nx   = cmd_byte;
    led_nx   = led_rgb;
    ledv_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        pend_nx = 1'b0;
        if (cs_fall || pend) begin
          state_nx = S_ACTIVE;
          tx_nx    = {x_in[7:0], x_in[15:8], y_in[7:0], y_in[15:8], fs_in};
          miso_nx  = x_in[7];
          cnt_nx   = '0;
          rx_nx    = '0;
          busy_nx  = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (cs_rise) begin
          state_nx = S_DONE;
          busy_nx  = 1'b0;
          miso_nx  = IDLE_MISO;
          done_nx  = 1'b1;
          if (bit_cnt == FRAME_BITS) begin
            cmd_nx = rx_sh[39:32];
            if (rx_sh[39:32] == CMD_SETLED) begin
              led_nx  = rx_sh[31:8];
              ledv_nx = 1'b1;
            end
          end else begin
            err_nx = 1'b1;
          end
        end else begin
          if (sck_rise) begin
            rx_nx = {rx_sh[38:0], mosi_s};
            if (bit_cnt != CNT_SAT) cnt_nx = bit_cnt + 6'd1;
          end
          if (sck_fall) begin
            tx_nx   = {tx_sh[38:0], 1'b0};
            miso_nx = (bit_cnt >= FRAME_BITS) ? IDLE_MISO : tx_sh[38];
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        if (cs_fall) pend_nx = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// tb_jstk2_spi_responder: directed bench acting as the SPI master for the
// joystick responder, with hand-computed packets and LED/command results.
module tb_jstk2_spi_responder;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] x_in = 16'h0;
  logic [15:0] y_in = 16'h0;
  logic [7:0]  fs_in = 8'h0;
  logic        busy, txn_done, frame_error, led_valid;
  logic [7:0]  cmd_byte;
  logic [23:0] led_rgb;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int ledv_cnt = 0;
  int ledv_aligned = 0;

  jstk2_spi_responder dut (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .x_in(x_in), .y_in(y_in), .fs_in(fs_in), .busy(busy), .txn_done(txn_done),
    .frame_error(frame_error), .cmd_byte(cmd_byte), .led_rgb(led_rgb), .led_valid(led_valid)
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  // Count the single-cycle status pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (txn_done === 1'b1) done_cnt++;
    if (frame_error === 1'b1) err_cnt++;
    if (led_valid === 1'b1) ledv_cnt++;
    if (led_valid === 1'b1 && txn_done === 1'b1) ledv_aligned++;
  end

  task automatic check_output(input string tag, input logic [39:0] observed, input logic [39:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one SPI mode-0 frame of nbits; miso is sampled just before each sck rise.
  task automatic apply_stimulus(input logic [39:0] mosi_bits, input int nbits, input bit raise_cs,
                                output logic [39:0] miso_bits, output logic tail_idle,
                                output logic busy_ok);
    miso_bits = '0;
    tail_idle = 1'b1;
    busy_ok = 1'b1;
    @(negedge clk);
    cs_n = 1'b0;
    mosi = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 40) ? mosi_bits[39-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      if (i < 40) miso_bits[39-i] = miso;
      else if (miso !== 1'b0) tail_idle = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    if (raise_cs) begin
      cs_n = 1'b1;
      repeat (12) @(negedge clk);
    end
  endtask

  logic [39:0] pkt;
  logic        tail_ok, busy_ok, busy_low;
  int          d0, e0, l0, a0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_output("rst_miso", {39'b0, miso}, 40'h0);
    check_output("rst_busy", {39'b0, busy}, 40'h0);
    check_output("rst_pulses", {37'b0, txn_done, frame_error, led_valid}, 40'h0);
    check_output("rst_cmd", {32'b0, cmd_byte}, 40'h0);
    check_output("rst_led", {16'b0, led_rgb}, 40'h0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Test 1: centred joystick, plain read
    x_in = 16'd128; y_in = 16'd128; fs_in = 8'h00;
    d0 = done_cnt; e0 = err_cnt;
    apply_stimulus(40'h0, 40, 1'b1, pkt, tail_ok, busy_ok);
    check_output("t1_packet", pkt, 40'h80_00_80_00_00);
    check_output("t1_busy_whole_frame", {39'b0, busy_ok}, 40'h1);
    check_output("t1_done_pulses", 40'(done_cnt - d0), 40'd1);
    check_output("t1_no_error", 40'(err_cnt - e0), 40'd0);
    check_output("t1_busy_after", {39'b0, busy}, 40'h0);

    // Test 2: x changes mid-frame, snapshot must hold
    x_in = 16'd32;
    fork
      apply_stimulus(40'h0, 40, 1'b1, pkt, tail_ok, busy_ok);
      begin
        repeat (100) @(negedge clk);
        x_in = 16'd200;
      end
    join
    check_output("t2_snapshot_32", pkt, 40'h20_00_80_00_00);
    apply_stimulus(40'h0, 40, 1'b1, pkt, tail_ok, busy_ok);
    check_output("t2_next_200", pkt, 40'hC8_00_80_00_00);

    // Test 3: SetLED command, then a non-LED command
    x_in = 16'h1234; y_in = 16'hABCD; fs_in = 8'h02;
    d0 = done_cnt; l0 = ledv_cnt; a0 = ledv_aligned;
    apply_stimulus(40'h84_FF_00_80_00, 40, 1'b1, pkt, tail_ok, busy_ok);
    check_output("t3_packet", pkt, 40'h34_12_CD_AB_02);
    check_output("t3_led_rgb", {16'b0, led_rgb}, 40'hFF0080);
    check_output("t3_cmd", {32'b0, cmd_byte}, 40'h84);
    check_output("t3_ledv_count", 40'(ledv_cnt - l0), 40'd1);
    check_output("t3_ledv_with_done", 40'(ledv_aligned - a0), 40'd1);
    l0 = ledv_cnt;
    apply_stimulus(40'hC0_11_22_33_44, 40, 1'b1, pkt, tail_ok, busy_ok);
    check_output("t3_cmd_c0", {32'b0, cmd_byte}, 40'hC0);
    check_output("t3_led_hold", {16'b0, led_rgb}, 40'hFF0080);
    check_output("t3_no_ledv", 40'(ledv_cnt - l0), 40'd0);

    // Test 4: aborted frame after 17 bits
    y_in = 16'h00FF; fs_in = 8'h00;
    d0 = done_cnt; e0 = err_cnt; l0 = ledv_cnt;
    apply_stimulus(40'h84_01_02_03_04, 17, 1'b0, pkt, tail_ok, busy_ok);
    check_output("t4_miso_mid", {39'b0, miso}, 40'h1);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
    check_output("t4_error", 40'(err_cnt - e0), 40'd1);
    check_output("t4_done", 40'(done_cnt - d0), 40'd1);
    check_output("t4_cmd_hold", {32'b0, cmd_byte}, 40'hC0);
    check_output("t4_led_hold", {16'b0, led_rgb}, 40'hFF0080);
    check_output("t4_no_ledv", 40'(ledv_cnt - l0), 40'd0);
    check_output("t4_miso_idle", {39'b0, miso}, 40'h0);
    e0 = err_cnt;
    apply_stimulus(40'hA5_00_00_00_00, 40, 1'b1, pkt, tail_ok, busy_ok);
    check_output("t4_next_packet", pkt, 40'h34_12_FF_00_00);
    check_output("t4_next_no_error", 40'(err_cnt - e0), 40'd0);
    check_output("t4_next_cmd", {32'b0, cmd_byte}, 40'hA5);

    // Test 5: over-clocked frame with 42 sck pulses
    fs_in = 8'h01;
    e0 = err_cnt;
    apply_stimulus(40'h84_12_34_56_00, 42, 1'b1, pkt, tail_ok, busy_ok);
    check_output("t5_packet", pkt, 40'h34_12_FF_00_01);
    check_output("t5_tail_idle", {39'b0, tail_ok}, 40'h1);
    check_output("t5_error", 40'(err_cnt - e0), 40'd1);
    check_output("t5_led_hold", {16'b0, led_rgb}, 40'hFF0080);
    check_output("t5_cmd_hold", {32'b0, cmd_byte}, 40'hA5);

    // Test 6: reset at bit 20, release mid-frame
    x_in = 16'd128; y_in = 16'd128; fs_in = 8'h00;
    apply_stimulus(40'h84_00_00_00_00, 20, 1'b0, pkt, tail_ok, busy_ok);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("t6_rst_miso", {39'b0, miso}, 40'h0);
    check_output("t6_rst_busy", {39'b0, busy}, 40'h0);
    check_output("t6_rst_cmd", {32'b0, cmd_byte}, 40'h0);
    check_output("t6_rst_led", {16'b0, led_rgb}, 40'h0);
    reset = 1'b1;
    d0 = done_cnt; e0 = err_cnt;
    busy_low = 1'b1;
    for (int i = 0; i < 5; i++) begin
      repeat (HALF) @(negedge clk);
      if (busy !== 1'b0) busy_low = 1'b0;
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
    check_output("t6_busy_ignored", {39'b0, busy_low}, 40'h1);
    check_output("t6_no_done", 40'(done_cnt - d0), 40'd0);
    check_output("t6_no_error", 40'(err_cnt - e0), 40'd0);
    apply_stimulus(40'h0, 40, 1'b1, pkt, tail_ok, busy_ok);
    check_output("t6_after_packet", pkt, 40'h80_00_80_00_00);
    check_output("t6_after_done", 40'(done_cnt - d0), 40'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
